// File: rtl/uart_prog_loader_pkg.sv
// Shared state encodings and protocol constants for the UART program loader.
// Package loader_pkg; imported by uart_rx_core and uart_prog_loader.
package loader_pkg;

  // Loader FSM states
  typedef enum logic [2:0] {
    LEN,
    DATA,
    WR,
    CHK,
    DONE,
    ERR
  } ld_state_t;

  // Receiver states
  typedef enum logic [1:0] {
    RX_IDLE,
    RX_START,
    RX_BITS,
    RX_STOP
  } rx_state_t;

  localparam int BYTES_PER_WORD = 4;
  localparam int LEN_BYTES      = 4;

  // Little-endian assembly: each new byte enters at the top and older bytes move down.
  function automatic logic [31:0] push_byte(input logic [31:0] acc, input logic [7:0] b);
    return {b, acc[31:8]};
  endfunction

endpackage

// File: rtl/uart_prog_loader_if.sv
// Instruction-memory write port and loader status, grouped for the loader top.
interface uart_prog_loader_if #(
  parameter int ADDR_W = 32
);
  logic              im_we;
  logic [ADDR_W-1:0] im_addr;
  logic [31:0]       im_wdata;
  logic              cpu_hold;
  logic              load_done;
  logic              load_err;
  logic [15:0]       words_loaded;

  modport master (
    output im_we, im_addr, im_wdata, cpu_hold, load_done, load_err, words_loaded
  );

  modport slave (
    input im_we, im_addr, im_wdata, cpu_hold, load_done, load_err, words_loaded
  );
endinterface

// File: rtl/uart_prog_loader_rx_core.sv
// 8N1 UART receiver: 2-flop synchronizer, down-counting bit timer, mid-bit sampling.
// state    | meaning
// RX_IDLE  | waiting for a high->low edge on the synchronized line
// RX_START | timing to mid start bit; a high sample there is a glitch
// RX_BITS  | sampling 8 data bits mid-bit, LSB first
// RX_STOP  | sampling stop bit; 1 -> rx_valid, 0 -> rx_frame_err
module uart_rx_core
  import loader_pkg::*;
#(
  parameter int CLKS_PER_BIT = 868
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       uart_rx,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  output logic       rx_frame_err
);

  localparam int TW = $clog2(CLKS_PER_BIT);
  localparam logic [TW-1:0] FULL = TW'(CLKS_PER_BIT - 1);
  localparam logic [TW-1:0] HALF = TW'(CLKS_PER_BIT / 2 - 1);

  logic [1:0]    sync;
  logic          rx_s;
  logic          rx_prev;
  rx_state_t     state, state_nxt;
  logic [TW-1:0] timer, timer_nxt;
  logic [2:0]    bit_cnt, bit_cnt_nxt;
  logic [7:0]    shift, shift_nxt;
  logic          valid_nxt, ferr_nxt;
  logic          tc;

  assign rx_s    = sync[1];
  assign tc      = (timer == '0);
  assign rx_data = shift;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync         <= 2'b11;
      rx_prev      <= 1'b1;
      state        <= RX_IDLE;
      timer        <= '0;
      bit_cnt      <= '0;
      shift        <= '0;
      rx_valid     <= 1'b0;
      rx_frame_err <= 1'b0;
    end else begin
      sync         <= {sync[0], uart_rx};
      rx_prev      <= rx_s;
      state        <= state_nxt;
      timer        <= timer_nxt;
      bit_cnt      <= bit_cnt_nxt;
      shift        <= shift_nxt;
      rx_valid     <= valid_nxt;
      rx_frame_err <= ferr_nxt;
    end
  end

  always_comb begin
    state_nxt   = state;
    timer_nxt   = timer;
    bit_cnt_nxt = bit_cnt;
    shift_nxt   = shift;
    valid_nxt   = 1'b0;
    ferr_nxt    = 1'b0;
    if (state != RX_IDLE && !tc) timer_nxt = timer - 1'b1;
    case (state)
      RX_IDLE: begin
        if (rx_prev && !rx_s) begin
          state_nxt = RX_START;
          timer_nxt = HALF;
        end
      end
      RX_START: begin
        if (tc) begin
          if (!rx_s) begin
            state_nxt   = RX_BITS;
            timer_nxt   = FULL;
            bit_cnt_nxt = '0;
          end else begin
            state_nxt = RX_IDLE;
          end
        end
      end
      RX_BITS: begin
        if (tc) begin
          shift_nxt = {rx_s, shift[7:1]};
          timer_nxt = FULL;
          if (bit_cnt == 3'd7) state_nxt = RX_STOP;
          else bit_cnt_nxt = bit_cnt + 1'b1;
        end
      end
      RX_STOP: begin
        if (tc) begin
          state_nxt = RX_IDLE;
          if (rx_s) valid_nxt = 1'b1;
          else ferr_nxt = 1'b1;
        end
      end
      default: state_nxt = RX_IDLE;
    endcase
  end

endmodule

// File: rtl/uart_prog_loader.sv
// Boot loader: receives a length-prefixed image over UART and writes it into instruction memory.
// Optional trailing XOR checksum word when LOADER_CHECKSUM_EN is defined.
// state | meaning
// LEN   | collecting 4-byte little-endian word count N
// DATA  | collecting 4 bytes of the next word
// WR    | single-cycle instruction-memory write
// CHK   | collecting 4-byte checksum (LOADER_CHECKSUM_EN only)
// DONE  | image loaded, core released; rx ignored
// ERR   | sticky error, core held; rx ignored
module uart_prog_loader
  import loader_pkg::*;
#(
  parameter int CLKS_PER_BIT = 868,
  parameter int ADDR_W       = 32,
  parameter int MAX_WORDS    = 1024
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                uart_rx,
  uart_prog_loader_if.master  bus
);

  localparam logic [1:0] LAST_WORD_BYTE = 2'(BYTES_PER_WORD - 1);
  localparam logic [1:0] LAST_LEN_BYTE  = 2'(LEN_BYTES - 1);

`ifdef LOADER_CHECKSUM_EN
  localparam ld_state_t AFTER_IMAGE = CHK;
`else
  localparam ld_state_t AFTER_IMAGE = DONE;
`endif

  ld_state_t         state, state_nxt;
  logic [7:0]        rx_data;
  logic              rx_valid;
  logic              rx_frame_err;
  logic [1:0]        byte_cnt;
  logic [31:0]       shreg;
  logic [31:0]       word_next;
  logic [31:0]       n_words;
  logic [15:0]       words_loaded;
  logic              im_we;
  logic [ADDR_W-1:0] im_addr;
  logic [31:0]       im_wdata;
  logic              collecting;
  logic              wr_go;
`ifdef LOADER_CHECKSUM_EN
  logic [31:0]       xor_acc;
`endif

  uart_rx_core #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_rx (
    .clk         (clk),
    .rst         (rst),
    .uart_rx     (uart_rx),
    .rx_data     (rx_data),
    .rx_valid    (rx_valid),
    .rx_frame_err(rx_frame_err)
  );

  assign word_next  = push_byte(shreg, rx_data);
  assign collecting = (state == LEN) || (state == DATA) || (state == CHK);

  always_comb begin
    state_nxt = state;
    wr_go     = 1'b0;
    case (state)
      LEN: begin
        if (rx_frame_err) state_nxt = ERR;
        else if (rx_valid && byte_cnt == LAST_LEN_BYTE) begin
          if (word_next == 32'd0) state_nxt = AFTER_IMAGE;
          else if (word_next > 32'(MAX_WORDS)) state_nxt = ERR;
          else state_nxt = DATA;
        end
      end
      DATA: begin
        if (rx_frame_err) state_nxt = ERR;
        else if (rx_valid && byte_cnt == LAST_WORD_BYTE) begin
          state_nxt = WR;
          wr_go     = 1'b1;
        end
      end
      // words_loaded already counts the word being written
      WR: begin
        if ({16'd0, words_loaded} < n_words) state_nxt = DATA;
        else state_nxt = AFTER_IMAGE;
      end
`ifdef LOADER_CHECKSUM_EN
      CHK: begin
        if (rx_frame_err) state_nxt = ERR;
        else if (rx_valid && byte_cnt == LAST_WORD_BYTE)
          state_nxt = (word_next == xor_acc) ? DONE : ERR;
      end
`endif
      DONE:    state_nxt = DONE;
      ERR:     state_nxt = ERR;
      default: state_nxt = ERR;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state        <= LEN;
      byte_cnt     <= '0;
      shreg        <= '0;
      n_words      <= '0;
      words_loaded <= '0;
      im_we        <= 1'b0;
      im_addr      <= '0;
      im_wdata     <= '0;
`ifdef LOADER_CHECKSUM_EN
      xor_acc      <= '0;
`endif
    end else begin
      state <= state_nxt;
      im_we <= wr_go;
      if (collecting && rx_valid) begin
        shreg    <= word_next;
        byte_cnt <= byte_cnt + 2'd1;
      end
      if (state == LEN && rx_valid && byte_cnt == LAST_LEN_BYTE) n_words <= word_next;
      if (wr_go) begin
        im_addr      <= ADDR_W'({words_loaded, 2'b00});
        im_wdata     <= word_next;
        words_loaded <= words_loaded + 16'd1;
`ifdef LOADER_CHECKSUM_EN
        xor_acc      <= xor_acc ^ word_next;
`endif
      end
    end
  end

  assign bus.im_we        = im_we;
  assign bus.im_addr      = im_addr;
  assign bus.im_wdata     = im_wdata;
  assign bus.words_loaded = words_loaded;
  assign bus.load_done    = (state == DONE);
  assign bus.load_err     = (state == ERR);
  assign bus.cpu_hold     = (state != DONE);

endmodule

// File: tb/tb_uart_prog_loader.sv
// Randomized self-checking bench for uart_prog_loader against an image-level reference model.
module tb_uart_prog_loader;

  localparam int CPB       = 8;
  localparam int ADDR_W    = 32;
  localparam int MAX_WORDS = 1024;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic uart_rx = 1'b1;

  always #5 clk = ~clk;

  uart_prog_loader_if #(.ADDR_W(ADDR_W)) lif ();

  uart_prog_loader #(
    .CLKS_PER_BIT(CPB),
    .ADDR_W      (ADDR_W),
    .MAX_WORDS   (MAX_WORDS)
  ) dut (
    .clk    (clk),
    .rst    (rst),
    .uart_rx(uart_rx),
    .bus    (lif)
  );

  int          n_vec = 0;
  int          n_err = 0;
  logic [31:0] img[$];
  logic [63:0] wr_addr_q[$];
  logic [31:0] wr_data_q[$];
  bit          cks_bad = 1'b0;

  always @(negedge clk) begin
    if (rst && lif.im_we) begin
      wr_addr_q.push_back(64'(lif.im_addr));
      wr_data_q.push_back(lif.im_wdata);
    end
  end

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic send_byte(input logic [7:0] b, input logic stop);
    uart_rx = 1'b0;
    repeat (CPB) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      uart_rx = b[i];
      repeat (CPB) @(negedge clk);
    end
    uart_rx = stop;
    repeat (CPB) @(negedge clk);
    uart_rx = 1'b1;
    repeat (CPB) @(negedge clk);
  endtask

  task automatic send_word(input logic [31:0] w);
    for (int i = 0; i < 4; i++) send_byte(w[8*i +: 8], 1'b1);
  endtask

  task automatic reset_dut(input string tag);
    @(negedge clk);
    rst = 1'b0;
    uart_rx = 1'b1;
    repeat (4) @(negedge clk);
    chk($sformatf("%s/rst_we", tag), 64'(lif.im_we), 64'd0);
    chk($sformatf("%s/rst_addr", tag), 64'(lif.im_addr), 64'd0);
    chk($sformatf("%s/rst_wdata", tag), 64'(lif.im_wdata), 64'd0);
    chk($sformatf("%s/rst_hold", tag), 64'(lif.cpu_hold), 64'd1);
    chk($sformatf("%s/rst_done", tag), 64'(lif.load_done), 64'd0);
    chk($sformatf("%s/rst_err", tag), 64'(lif.load_err), 64'd0);
    chk($sformatf("%s/rst_words", tag), 64'(lif.words_loaded), 64'd0);
    wr_addr_q.delete();
    wr_data_q.delete();
    rst = 1'b1;
    repeat (2 * CPB) @(negedge clk);
  endtask

  task automatic glitch();
    uart_rx = 1'b0;
    repeat (2) @(negedge clk);
    uart_rx = 1'b1;
    repeat (3 * CPB) @(negedge clk);
  endtask

  // Send length, then the image (or junk words when N is oversized), then checksum if enabled.
  task automatic load_img(input int n);
    logic [31:0] x;
    x = '0;
    send_word(32'(n));
    if (n > MAX_WORDS) begin
      for (int i = 0; i < img.size(); i++) send_word(img[i]);
    end else begin
      for (int i = 0; i < n; i++) begin
        send_word(img[i]);
        x ^= img[i];
      end
`ifdef LOADER_CHECKSUM_EN
      send_word(cks_bad ? (x ^ 32'h1) : x);
`endif
    end
  endtask

  task automatic verify(input string tag, input int nw, input bit ok);
    repeat (3 * CPB) @(negedge clk);
    chk($sformatf("%s/n_writes", tag), 64'(wr_addr_q.size()), 64'(nw));
    for (int i = 0; i < nw && i < wr_addr_q.size(); i++) begin
      chk($sformatf("%s/addr%0d", tag, i), wr_addr_q[i], 64'(4 * i));
      chk($sformatf("%s/data%0d", tag, i), 64'(wr_data_q[i]), 64'(img[i]));
    end
    chk($sformatf("%s/words", tag), 64'(lif.words_loaded), 64'(nw));
    chk($sformatf("%s/done", tag), 64'(lif.load_done), 64'(ok));
    chk($sformatf("%s/err", tag), 64'(lif.load_err), 64'(!ok));
    chk($sformatf("%s/hold", tag), 64'(lif.cpu_hold), 64'(!ok));
    chk($sformatf("%s/we_idle", tag), 64'(lif.im_we), 64'd0);
  endtask

  initial begin
    int n;

    // Directed three-word image with a leading line glitch
    reset_dut("t1");
    glitch();
    img = '{32'h00000013, 32'h00100093, 32'hDEADBEEF};
    load_img(3);
    verify("t1", 3, 1'b1);

    // Empty image: nothing written, done only after the last length byte
    reset_dut("t2");
    img.delete();
    for (int i = 0; i < 3; i++) send_byte(8'h00, 1'b1);
    chk("t2/done_early", 64'(lif.load_done), 64'd0);
    send_byte(8'h00, 1'b1);
`ifdef LOADER_CHECKSUM_EN
    send_word(32'h0);
`endif
    verify("t2", 0, 1'b1);

    // Oversized length is rejected; trailing bytes ignored
    reset_dut("t3");
    img = '{32'h11111111, 32'h22222222};
    load_img(MAX_WORDS + 1);
    verify("t3", 0, 1'b0);

    // Framing error on byte 2 of word 1
    reset_dut("t4");
    img = '{32'hCAFEF00D, 32'h0BADBEEF};
    send_word(32'd2);
    send_word(img[0]);
    send_byte(img[1][7:0], 1'b1);
    send_byte(img[1][15:8], 1'b0);
    send_byte(img[1][23:16], 1'b1);
    send_word(32'hA5A5A5A5);
    verify("t4", 1, 1'b0);

    // Reset mid-load, then a fresh single-word load
    reset_dut("t5a");
    img = '{32'h01020304, 32'h05060708, 32'h090A0B0C, 32'h0D0E0F10};
    send_word(32'd4);
    send_word(img[0]);
    send_byte(img[1][7:0], 1'b1);
    send_byte(img[1][15:8], 1'b1);
    uart_rx = 1'b0;
    repeat (3 * CPB) @(negedge clk);
    reset_dut("t5b");
    img = '{32'h12345678};
    load_img(1);
    verify("t5", 1, 1'b1);

`ifdef LOADER_CHECKSUM_EN
    reset_dut("t6a");
    img = '{32'h0F0F0F0F, 32'h00FF00FF};
    cks_bad = 1'b0;
    load_img(2);
    verify("t6a", 2, 1'b1);
    reset_dut("t6b");
    cks_bad = 1'b1;
    load_img(2);
    verify("t6b", 2, 1'b0);
    cks_bad = 1'b0;
`endif

    // Randomized images
    for (int k = 0; k < 8; k++) begin
      reset_dut($sformatf("r%0d", k));
      if ($urandom_range(0, 1) == 1) glitch();
      n = $urandom_range(1, 5);
      img.delete();
      for (int i = 0; i < n; i++) img.push_back($urandom());
`ifdef LOADER_CHECKSUM_EN
      cks_bad = ($urandom_range(0, 3) == 0);
`endif
      load_img(n);
      verify($sformatf("r%0d", k), n, !cks_bad);
      cks_bad = 1'b0;
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
